// File: rtl/stair_scheduler_if.sv
// Start-control and pixel-port bundle between a host and stair_scheduler.
interface stair_scheduler_if;
    logic       go;
    logic [7:0] stair0_x;
    logic [7:0] stair1_x;
    logic [6:0] stair0_y;
    logic [6:0] stair1_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       stair_sel;
    logic       busy;
    logic       step_pulse;
    logic [2:0] state;

    modport master (
        output go, stair0_x, stair1_x, stair0_y, stair1_y,
        input  x, y, colour, plot, stair_sel, busy, step_pulse, state
    );

    modport slave (
        input  go, stair0_x, stair1_x, stair0_y, stair1_y,
        output x, y, colour, plot, stair_sel, busy, step_pulse, state
    );
endinterface

// File: rtl/stair_scheduler.sv
// Shares one VGA pixel-write port between two stairs: draw both, hold for a
// number of frames, erase both, move both up one row, repeat.
module stair_scheduler #(
    parameter int         STAIR_W         = 40,
    parameter int         STAIR_H         = 5,
    parameter int         FRAME_CYCLES    = 833334,
    parameter int         FRAMES_PER_STEP = 4,
    parameter int         Y_WRAP          = 116,
    parameter logic [2:0] DRAW_COLOUR     = 3'b100
) (
    input logic               clock,
    input logic               reset_n,
    stair_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_DRAW  = 3'd2,
        S_WAIT  = 3'd3,
        S_ERASE = 3'd4,
        S_MOVE  = 3'd5
    } state_t;

    localparam logic [7:0]  XO_LAST = 8'(STAIR_W - 1);
    localparam logic [6:0]  YO_LAST = 7'(STAIR_H - 1);
    localparam logic [19:0] FC_LAST = 20'(FRAME_CYCLES - 1);
    localparam logic [15:0] FN_LAST = 16'(FRAMES_PER_STEP - 1);
    localparam logic [6:0]  Y_WRAP_V = 7'(Y_WRAP);

    state_t      state_q, state_d;
    logic [7:0]  sx0_q, sx0_d, sx1_q, sx1_d;
    logic [6:0]  sy0_q, sy0_d, sy1_q, sy1_d;
    logic [7:0]  xo_q, xo_d;
    logic [6:0]  yo_q, yo_d;
    logic        sel_q, sel_d;
    logic [19:0] fcnt_q, fcnt_d;
    logic [15:0] fnum_q, fnum_d;

    logic        plot_s;
    logic [2:0]  colour_s;
    logic [7:0]  x_s;
    logic [6:0]  y_s;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sx0_q   <= 8'd0;
            sx1_q   <= 8'd0;
            sy0_q   <= 7'd0;
            sy1_q   <= 7'd0;
            xo_q    <= 8'd0;
            yo_q    <= 7'd0;
            sel_q   <= 1'b0;
            fcnt_q  <= 20'd0;
            fnum_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            sx0_q   <= sx0_d;
            sx1_q   <= sx1_d;
            sy0_q   <= sy0_d;
            sy1_q   <= sy1_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            sel_q   <= sel_d;
            fcnt_q  <= fcnt_d;
            fnum_q  <= fnum_d;
        end
    end

    // Next-state logic: sequencing, raster scan, hold timer and row move.
    always_comb begin
        state_d = state_q;
        sx0_d   = sx0_q;
        sx1_d   = sx1_q;
        sy0_d   = sy0_q;
        sy1_d   = sy1_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        sel_d   = sel_q;
        fcnt_d  = fcnt_q;
        fnum_d  = fnum_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (!bus.go) begin
                    state_d = S_DRAW;
                    sx0_d   = bus.stair0_x;
                    sx1_d   = bus.stair1_x;
                    sy0_d   = bus.stair0_y;
                    sy1_d   = bus.stair1_y;
                    xo_d    = 8'd0;
                    yo_d    = 7'd0;
                    sel_d   = 1'b0;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_DRAW, S_ERASE: begin
                if (xo_q == XO_LAST) begin
                    xo_d = 8'd0;
                    if (yo_q == YO_LAST) begin
                        yo_d  = 7'd0;
                        sel_d = ~sel_q;
                        // Finishing stair 1 ends the pass; the hold timer starts clean.
                        if (sel_q) begin
                            state_d = (state_q == S_DRAW) ? S_WAIT : S_MOVE;
                            fcnt_d  = 20'd0;
                            fnum_d  = 16'd0;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        yo_d = yo_q + 7'd1;
                    end
                end else begin
                    xo_d = xo_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (fcnt_q == FC_LAST) begin
                    fcnt_d = 20'd0;
                    if (fnum_q == FN_LAST) begin
                        state_d = S_ERASE;
                        fnum_d  = 16'd0;
                    end else begin
                        fnum_d = fnum_q + 16'd1;
                    end
                end else begin
                    fcnt_d = fcnt_q + 20'd1;
                end
            end
            S_MOVE: begin
                sy0_d   = (sy0_q == 7'd0) ? Y_WRAP_V : (sy0_q - 7'd1);
                sy1_d   = (sy1_q == 7'd0) ? Y_WRAP_V : (sy1_q - 7'd1);
                state_d = S_DRAW;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore pixel-port decode from registered state only.
    always_comb begin
        plot_s   = 1'b0;
        colour_s = 3'b000;
        x_s      = 8'd0;
        y_s      = 7'd0;
        if (state_q == S_DRAW || state_q == S_ERASE) begin
            plot_s   = 1'b1;
            colour_s = (state_q == S_DRAW) ? DRAW_COLOUR : 3'b000;
            x_s      = (sel_q ? sx1_q : sx0_q) + xo_q;
            y_s      = (sel_q ? sy1_q : sy0_q) + yo_q;
        end else begin
            plot_s = 1'b0;
        end
    end

    assign bus.plot       = plot_s;
    assign bus.colour     = colour_s;
    assign bus.x          = x_s;
    assign bus.y          = y_s;
    assign bus.stair_sel  = sel_q;
    assign bus.busy       = (state_q == S_DRAW) || (state_q == S_WAIT) ||
                            (state_q == S_ERASE) || (state_q == S_MOVE);
    assign bus.step_pulse = (state_q == S_MOVE);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_stair_scheduler.sv
// Directed bench for stair_scheduler with a short hold (5 cycles x 4 frames).
module tb_stair_scheduler;
    localparam int W    = 40;
    localparam int H    = 5;
    localparam int NPIX = W * H;
    localparam int HOLD = 20;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    stair_scheduler_if bus ();

    stair_scheduler #(
        .STAIR_W        (40),
        .STAIR_H        (5),
        .FRAME_CYCLES   (5),
        .FRAMES_PER_STEP(4),
        .Y_WRAP         (116),
        .DRAW_COLOUR    (3'b100)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".state"},  32'(bus.state), 32'd0);
        check_eq({tag, ".plot"},   32'(bus.plot), 32'd0);
        check_eq({tag, ".x"},      32'(bus.x), 32'd0);
        check_eq({tag, ".y"},      32'(bus.y), 32'd0);
        check_eq({tag, ".colour"}, 32'(bus.colour), 32'd0);
        check_eq({tag, ".sel"},    32'(bus.stair_sel), 32'd0);
        check_eq({tag, ".busy"},   32'(bus.busy), 32'd0);
        check_eq({tag, ".step"},   32'(bus.step_pulse), 32'd0);
    endtask

    // Assert reset between edges and confirm outputs drop without a clock.
    task automatic async_reset(input string tag);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_quiet(tag);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // go pulse: one cycle in ARM, then the next edge enters DRAW.
    task automatic start(input logic [7:0] x0, input logic [6:0] y0,
                         input logic [7:0] x1, input logic [6:0] y1);
        @(negedge clock);
        bus.stair0_x = x0;
        bus.stair0_y = y0;
        bus.stair1_x = x1;
        bus.stair1_y = y1;
        bus.go       = 1'b1;
        @(negedge clock);
        check_eq("arm.state", 32'(bus.state), 32'd1);
        bus.go = 1'b0;
    endtask

    task automatic scan(input string tag, input int npix,
                        input logic [7:0] x0, input logic [6:0] y0,
                        input logic [7:0] x1, input logic [6:0] y1,
                        input logic [2:0] col, input logic [2:0] st);
        int         s;
        int         p;
        logic [7:0] ex;
        logic [6:0] ey;
        for (int i = 0; i < npix; i++) begin
            @(negedge clock);
            s  = i / NPIX;
            p  = i % NPIX;
            ex = ((s == 0) ? x0 : x1) + 8'(p % W);
            ey = ((s == 0) ? y0 : y1) + 7'(p / W);
            check_eq($sformatf("%s[%0d].x", tag, i),      32'(bus.x), 32'(ex));
            check_eq($sformatf("%s[%0d].y", tag, i),      32'(bus.y), 32'(ey));
            check_eq($sformatf("%s[%0d].plot", tag, i),   32'(bus.plot), 32'd1);
            check_eq($sformatf("%s[%0d].colour", tag, i), 32'(bus.colour), 32'(col));
            check_eq($sformatf("%s[%0d].sel", tag, i),    32'(bus.stair_sel), 32'(s));
            check_eq($sformatf("%s[%0d].state", tag, i),  32'(bus.state), 32'(st));
        end
    endtask

    task automatic hold_and_move(input string tag);
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clock);
            check_eq($sformatf("%s.wait[%0d].plot", tag, i),  32'(bus.plot), 32'd0);
            check_eq($sformatf("%s.wait[%0d].state", tag, i), 32'(bus.state), 32'd3);
            check_eq($sformatf("%s.wait[%0d].busy", tag, i),  32'(bus.busy), 32'd1);
            check_eq($sformatf("%s.wait[%0d].step", tag, i),  32'(bus.step_pulse), 32'd0);
        end
    endtask

    task automatic check_move(input string tag);
        @(negedge clock);
        check_eq({tag, ".move.step"},  32'(bus.step_pulse), 32'd1);
        check_eq({tag, ".move.state"}, 32'(bus.state), 32'd5);
        check_eq({tag, ".move.plot"},  32'(bus.plot), 32'd0);
        check_eq({tag, ".move.busy"},  32'(bus.busy), 32'd1);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset_n      = 1'b0;
        bus.go       = 1'b0;
        bus.stair0_x = 8'd0;
        bus.stair1_x = 8'd0;
        bus.stair0_y = 7'd0;
        bus.stair1_y = 7'd0;
        #3 check_quiet("por");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_quiet("idle");

        // go held high: stays in ARM with no plotting.
        bus.go = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check_eq($sformatf("armhold[%0d].state", i), 32'(bus.state), 32'd1);
            check_eq($sformatf("armhold[%0d].plot", i),  32'(bus.plot), 32'd0);
        end
        bus.stair0_x = 8'd60;
        bus.stair0_y = 7'd40;
        bus.stair1_x = 8'd100;
        bus.stair1_y = 7'd20;
        bus.go       = 1'b0;

        scan("draw1", 2 * NPIX, 8'd60, 7'd40, 8'd100, 7'd20, 3'b100, 3'd2);
        hold_and_move("s1");
        scan("erase1", 2 * NPIX, 8'd60, 7'd40, 8'd100, 7'd20, 3'b000, 3'd4);
        check_move("s1");
        scan("draw2", 2 * NPIX, 8'd60, 7'd39, 8'd100, 7'd19, 3'b100, 3'd2);

        // Abort mid-draw at pixel 57, then restart with new inputs (x wraps).
        async_reset("rst_wait");
        start(8'd60, 7'd40, 8'd100, 7'd20);
        scan("part", 58, 8'd60, 7'd40, 8'd100, 7'd20, 3'b100, 3'd2);
        async_reset("rst_draw");
        start(8'd5, 7'd10, 8'd230, 7'd100);
        scan("restart", 2 * NPIX, 8'd5, 7'd10, 8'd230, 7'd100, 3'b100, 3'd2);

        // Row wrap on move from 0 and on the y adder.
        async_reset("rst_wrap");
        start(8'd10, 7'd0, 8'd30, 7'd126);
        scan("wdraw1", 2 * NPIX, 8'd10, 7'd0, 8'd30, 7'd126, 3'b100, 3'd2);
        hold_and_move("w");
        scan("werase", 2 * NPIX, 8'd10, 7'd0, 8'd30, 7'd126, 3'b000, 3'd4);
        check_move("w");
        scan("wdraw2", 2 * NPIX, 8'd10, 7'd116, 8'd30, 7'd125, 3'b100, 3'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
